// File: rtl/shifter_operand_pipe_if.sv
// shifter_operand_pipe_if: request/result handshake bundle for the shifter-operand pipe
interface shifter_operand_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_type;
  logic [11:0]      in_operand;
  logic [WIDTH-1:0] in_rm;
  logic [7:0]       in_rs;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_carry;
  logic             out_err;
  modport master (
    output in_valid, in_type, in_operand, in_rm, in_rs, in_carry, out_ready,
    input  in_ready, out_valid, out_value, out_carry, out_err
  );
  modport slave (
    input  in_valid, in_type, in_operand, in_rm, in_rs, in_carry, out_ready,
    output in_ready, out_valid, out_value, out_carry, out_err
  );
endinterface

// File: rtl/shifter_operand_pipe.sv
// shifter_operand_pipe: two-stage ARM shifter-operand generator (decode, then barrel shift) with valid/ready
module shifter_operand_pipe #(
  parameter  int WIDTH = 32,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input logic                   clk,
  input logic                   reset_n,
  shifter_operand_pipe_if.slave bus
);
  localparam logic [AMT_W:0] AMT_N   = (AMT_W+1)'(WIDTH);
  localparam logic [AMT_W:0] AMT_SAT = (AMT_W+1)'(WIDTH + 1);
  localparam logic [8:0]     W9      = 9'(WIDTH);
  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  logic [1:0]       s1_op, d_op, sh_op;
  logic [AMT_W:0]   s1_amt, d_amt, imm_amt, rs_amt;
  logic [WIDTH-1:0] s1_src, d_src;
  logic             s1_c, s1_rrx, s1_err, d_rrx, d_err;
  logic [4:0]       sh_imm;
  logic [3:0]       rot;
  logic [7:0]       imm8;
  logic [AMT_W-1:0] rs_mod;
  logic [WIDTH:0]   lsl_t, lsr_t;
  logic signed [WIDTH:0] asr_t;
  logic [WIDTH-1:0] ror_v, r_value, out_value;
  logic             r_carry, out_carry, out_err;
  assign s2_adv        = !s2_valid || bus.out_ready;
  assign s1_adv        = !s1_valid || s2_adv;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_value = out_value;
  assign bus.out_carry = out_carry;
  assign bus.out_err   = out_err;
  // Every form is reduced to {op, amount, source}; amounts of 0 always mean "pass through with C"
  always_comb begin
    sh_imm  = bus.in_operand[11:7];
    sh_op   = bus.in_operand[6:5];
    rot     = bus.in_operand[11:8];
    imm8    = bus.in_operand[7:0];
    imm_amt = (AMT_W+1)'(sh_imm);
    rs_mod  = bus.in_rs[AMT_W-1:0];
    rs_amt  = bus.in_rs == 8'd0 ? '0
            : sh_op == 2'd3 ? (rs_mod == '0 ? AMT_N : {1'b0, rs_mod})
            : {1'b0, bus.in_rs} > W9 ? AMT_SAT : bus.in_rs[AMT_W:0];
    d_op  = sh_op;
    d_src = bus.in_rm;
    d_amt = imm_amt;
    d_rrx = 1'b0;
    d_err = 1'b0;
    case (bus.in_type)
      3'b000, 3'b011: begin
        d_amt = sh_imm != 5'd0 ? imm_amt : (sh_op == 2'd1 || sh_op == 2'd2) ? AMT_N : '0;
        d_rrx = sh_imm == 5'd0 && sh_op == 2'd3;
      end
      3'b001: begin
        d_op  = 2'd3;
        d_src = WIDTH'(imm8);
        d_amt = (AMT_W+1)'({rot, 1'b0});
      end
      3'b010: begin
        d_op  = 2'd0;
        d_src = WIDTH'(bus.in_operand);
        d_amt = '0;
      end
      3'b100: d_amt = rs_amt;
      default: begin
        d_op  = 2'd0;
        d_src = '0;
        d_amt = '0;
        d_err = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= bus.in_valid;
  always_ff @(posedge clk)
    if (s1_adv && bus.in_valid) begin
      s1_op  <= d_op;
      s1_amt <= d_amt;
      s1_src <= d_src;
      s1_c   <= bus.in_carry;
      s1_rrx <= d_rrx;
      s1_err <= d_err;
    end
  // One guard bit beyond the word captures the last bit shifted out, including the n = W case
  always_comb begin
    lsl_t   = {1'b0, s1_src} << s1_amt;
    lsr_t   = {s1_src, 1'b0} >> s1_amt;
    asr_t   = $signed({s1_src, 1'b0}) >>> s1_amt;
    ror_v   = (s1_src >> s1_amt) | (s1_src << (AMT_N - s1_amt));
    r_value = s1_rrx ? {s1_c, s1_src[WIDTH-1:1]}
            : s1_amt == '0 ? s1_src
            : s1_op == 2'd0 ? lsl_t[WIDTH-1:0]
            : s1_op == 2'd1 ? lsr_t[WIDTH:1]
            : s1_op == 2'd2 ? asr_t[WIDTH:1]
            : ror_v;
    r_carry = s1_rrx ? s1_src[0]
            : s1_amt == '0 ? s1_c
            : s1_op == 2'd0 ? lsl_t[WIDTH]
            : s1_op == 2'd1 ? lsr_t[0]
            : s1_op == 2'd2 ? asr_t[0]
            : ror_v[WIDTH-1];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      out_value <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_value <= r_value;
        out_carry <= r_carry;
        out_err   <= s1_err;
      end
    end
endmodule

// File: tb/tb_shifter_operand_pipe.sv
// tb_shifter_operand_pipe: directed vector table plus backpressure, streaming and reset sequences
module tb_shifter_operand_pipe;
  localparam int W = 32;
  localparam logic [31:0] RM = 32'hEB000007;
  typedef struct {
    logic [2:0]  typ;
    logic [11:0] opnd;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        c;
    logic [31:0] val;
    logic        vc;
    logic        err;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  vec_t vt[$];
  vec_t va, vb, vc;
  shifter_operand_pipe_if #(.WIDTH(W)) bus();
  shifter_operand_pipe #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  function automatic vec_t mk(input logic [2:0] typ, input logic [11:0] opnd, input logic [31:0] rm,
                              input logic [7:0] rs, input logic c, input logic [31:0] val,
                              input logic vcar, input logic err);
    vec_t r;
    r.typ = typ; r.opnd = opnd; r.rm = rm; r.rs = rs; r.c = c;
    r.val = val; r.vc = vcar; r.err = err;
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.in_type = v.typ;
    bus.in_operand = v.opnd;
    bus.in_rm = v.rm;
    bus.in_rs = v.rs;
    bus.in_carry = v.c;
    bus.in_valid = 1'b1;
  endtask
  task automatic check_out(input string name, input vec_t v);
    check({name, "_valid"}, 64'(bus.out_valid), 64'(1'b1));
    check({name, "_value"}, 64'(bus.out_value), 64'(v.val));
    check({name, "_carry"}, 64'(bus.out_carry), 64'(v.vc));
    check({name, "_err"}, 64'(bus.out_err), 64'(v.err));
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    @(negedge clk);
    drive(v);
    #1 check($sformatf("v%0d_in_ready", idx), 64'(bus.in_ready), 64'(1'b1));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d_latency", idx), 64'(cyc), 64'(2));
    check_out($sformatf("v%0d", idx), v);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_type = '0;
    bus.in_operand = '0;
    bus.in_rm = '0;
    bus.in_rs = '0;
    bus.in_carry = 1'b0;
    bus.out_ready = 1'b1;
    vt.push_back(mk(3'd0, 12'h387, RM, 8'd0,   1'b0, 32'h80000380, 1'b1, 1'b0));
    vt.push_back(mk(3'd0, 12'h020, RM, 8'd0,   1'b1, 32'h00000000, 1'b1, 1'b0));
    vt.push_back(mk(3'd0, 12'h060, RM, 8'd0,   1'b0, 32'h75800003, 1'b1, 1'b0));
    vt.push_back(mk(3'd0, 12'h040, RM, 8'd0,   1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    vt.push_back(mk(3'd0, 12'h220, RM, 8'd0,   1'b1, 32'h0EB00000, 1'b0, 1'b0));
    vt.push_back(mk(3'd0, 12'h240, RM, 8'd0,   1'b0, 32'hFEB00000, 1'b0, 1'b0));
    vt.push_back(mk(3'd0, 12'h260, RM, 8'd0,   1'b0, 32'h7EB00000, 1'b0, 1'b0));
    vt.push_back(mk(3'd3, 12'h080, RM, 8'd0,   1'b0, 32'hD600000E, 1'b1, 1'b0));
    vt.push_back(mk(3'd3, 12'h060, RM, 8'd0,   1'b1, 32'hF5800003, 1'b1, 1'b0));
    vt.push_back(mk(3'd4, 12'h000, RM, 8'd32,  1'b0, 32'h00000000, 1'b1, 1'b0));
    vt.push_back(mk(3'd4, 12'h040, RM, 8'd40,  1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    vt.push_back(mk(3'd4, 12'h060, RM, 8'd0,   1'b0, 32'hEB000007, 1'b0, 1'b0));
    vt.push_back(mk(3'd4, 12'h000, RM, 8'd0,   1'b1, 32'hEB000007, 1'b1, 1'b0));
    vt.push_back(mk(3'd4, 12'h020, RM, 8'd32,  1'b0, 32'h00000000, 1'b1, 1'b0));
    vt.push_back(mk(3'd4, 12'h020, RM, 8'd33,  1'b1, 32'h00000000, 1'b0, 1'b0));
    vt.push_back(mk(3'd4, 12'h000, RM, 8'd33,  1'b1, 32'h00000000, 1'b0, 1'b0));
    vt.push_back(mk(3'd4, 12'h060, RM, 8'd32,  1'b0, 32'hEB000007, 1'b1, 1'b0));
    vt.push_back(mk(3'd4, 12'h060, RM, 8'd36,  1'b1, 32'h7EB00000, 1'b0, 1'b0));
    vt.push_back(mk(3'd4, 12'h000, RM, 8'd4,   1'b1, 32'hB0000070, 1'b0, 1'b0));
    vt.push_back(mk(3'd4, 12'h020, RM, 8'd255, 1'b1, 32'h00000000, 1'b0, 1'b0));
    vt.push_back(mk(3'd4, 12'h040, RM, 8'd31,  1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    vt.push_back(mk(3'd4, 12'h040, 32'h40000000, 8'd200, 1'b1, 32'h00000000, 1'b0, 1'b0));
    vt.push_back(mk(3'd4, 12'h060, RM, 8'd8,   1'b1, 32'h07EB0000, 1'b0, 1'b0));
    vt.push_back(mk(3'd1, 12'h4FF, RM, 8'd0,   1'b0, 32'hFF000000, 1'b1, 1'b0));
    vt.push_back(mk(3'd1, 12'h0AB, RM, 8'd0,   1'b1, 32'h000000AB, 1'b1, 1'b0));
    vt.push_back(mk(3'd1, 12'h102, RM, 8'd0,   1'b0, 32'h80000000, 1'b1, 1'b0));
    vt.push_back(mk(3'd1, 12'hF0F, RM, 8'd0,   1'b1, 32'h0000003C, 1'b0, 1'b0));
    vt.push_back(mk(3'd2, 12'h5D5, RM, 8'd0,   1'b1, 32'h000005D5, 1'b1, 1'b0));
    vt.push_back(mk(3'd2, 12'h5D5, RM, 8'd0,   1'b0, 32'h000005D5, 1'b0, 1'b0));
    vt.push_back(mk(3'd7, 12'hFFF, RM, 8'd0,   1'b0, 32'h00000000, 1'b0, 1'b1));
    vt.push_back(mk(3'd5, 12'h387, RM, 8'd0,   1'b1, 32'h00000000, 1'b1, 1'b1));
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    check("rst_out_value", 64'(bus.out_value), 64'(0));
    check("rst_out_carry", 64'(bus.out_carry), 64'(1'b0));
    check("rst_out_err", 64'(bus.out_err), 64'(1'b0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    reset_n = 1'b1;
    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);
    // three back-to-back requests against a stalled consumer
    va = vt[0];
    vb = vt[23];
    vc = vt[29];
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(va);
    #1 check("bp_rdy_a", 64'(bus.in_ready), 64'(1'b1));
    @(negedge clk);
    drive(vb);
    #1 check("bp_rdy_b", 64'(bus.in_ready), 64'(1'b1));
    @(negedge clk);
    drive(vc);
    #1 check("bp_rdy_full", 64'(bus.in_ready), 64'(1'b0));
    check_out("bp_head", va);
    repeat (2) begin
      @(negedge clk);
      #1 check("bp_hold_rdy", 64'(bus.in_ready), 64'(1'b0));
      check_out("bp_hold", va);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 check("bp_rdy_release", 64'(bus.in_ready), 64'(1'b1));
    check_out("bp_out_a", va);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check_out("bp_out_b", vb);
    @(negedge clk);
    #1 check_out("bp_out_c", vc);
    @(negedge clk);
    #1 check("bp_drained", 64'(bus.out_valid), 64'(1'b0));
    // continuous stream: no bubbles
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) drive(vt[i]);
      else bus.in_valid = 1'b0;
      #1;
      if (i < 4) check($sformatf("st%0d_in_ready", i), 64'(bus.in_ready), 64'(1'b1));
      if (i >= 2) check_out($sformatf("st%0d", i - 2), vt[i - 2]);
    end
    @(negedge clk);
    #1 check("st_drained", 64'(bus.out_valid), 64'(1'b0));
    // reset with two requests in flight
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(vt[0]);
    @(negedge clk);
    drive(vt[1]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("rr_inflight_valid", 64'(bus.out_valid), 64'(1'b1));
    #1 reset_n = 1'b0;
    #1 check("rr_async_valid", 64'(bus.out_valid), 64'(1'b0));
    check("rr_async_value", 64'(bus.out_value), 64'(0));
    check("rr_async_ready", 64'(bus.in_ready), 64'(1'b1));
    @(negedge clk);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    run_vec(vt[4], 100);
    @(negedge clk);
    #1 check("rr_single_only", 64'(bus.out_valid), 64'(1'b0));
    @(negedge clk);
    #1 check("rr_still_empty", 64'(bus.out_valid), 64'(1'b0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
